// File: rtl/serial_parallel_if.sv
// rtl/serial_parallel_if.sv - CPU/serial-line bundle for the serial receiver
//
// Purpose : groups the serial input, the CPU controls and the CPU-visible
//           receive results of serial_parallel into one bundle.
// Signals : in           - serial line, idles high, asynchronous to clk
//           enable       - receiver enable
//           read         - one-cycle CPU acknowledge
//           toCPU        - last good character
//           charReceived - character waiting for the CPU
//           frameError   - most recent frame had a low stop bit
//           overrun      - a character arrived while one was still waiting
// Modports: master (line/CPU side) drives in/enable/read;
//           slave (receiver) drives the results.
interface serial_parallel_if #(
    parameter int DATA_BITS = 8
);
    logic                 in;
    logic                 enable;
    logic                 read;
    logic [DATA_BITS-1:0] toCPU;
    logic                 charReceived;
    logic                 frameError;
    logic                 overrun;

    modport master (
        output in, enable, read,
        input  toCPU, charReceived, frameError, overrun
    );

    modport slave (
        input  in, enable, read,
        output toCPU, charReceived, frameError, overrun
    );
endinterface

// File: rtl/serial_parallel.sv
// rtl/serial_parallel.sv - asynchronous serial receiver with mid-bit sampling
//
// Purpose : synchronizes the serial line, detects a start bit, samples each
//           bit at its mid-point with a clk-based counter, assembles one
//           LSB-first character and reports it to the CPU with received,
//           framing-error and overrun flags.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-low reset
//           bus   - serial_parallel_if.slave (in, enable, read, toCPU,
//                   charReceived, frameError, overrun)
module serial_parallel #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_parallel_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 s_meta;
    logic                 s;
    logic                 armed;
    logic                 done;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] to_cpu;
    logic                 char_rx;
    logic                 frame_err;
    logic                 ovr;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
        end else begin
            s_meta <= bus.in;
            s      <= s_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            to_cpu    <= '0;
            char_rx   <= 1'b0;
            frame_err <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            done <= 1'b0;

            // A good stop bit is published one edge after it was sampled.
            // A read landing on that same edge loses: the new character
            // stays flagged and the acknowledge clears the overrun.
            if (done) begin
                to_cpu    <= shreg;
                char_rx   <= 1'b1;
                frame_err <= 1'b0;
                ovr       <= char_rx && !bus.read;
            end else if (bus.read) begin
                char_rx <= 1'b0;
                ovr     <= 1'b0;
            end

            // A start needs a high line seen while idle first, so a line that
            // is already low (break, re-enable mid-frame) cannot trigger one.
            armed <= (state == IDLE) && s;

            if (!bus.enable) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed && !s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_LAST) begin
                            cnt   <= '0;
                            shreg <= {s, shreg[DATA_BITS-1:1]};
                            idx   <= idx + 1'b1;
                            if (idx == IDX_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == FULL_LAST) begin
                            cnt <= '0;
                            if (s) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.toCPU        = to_cpu;
    assign bus.charReceived = char_rx;
    assign bus.frameError   = frame_err;
    assign bus.overrun      = ovr;

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
- Receive-side counterpart of the parallel-to-serial transmitter in lab 4.
- Watches one asynchronous serial line, detects a start bit and samples each bit at mid-period using a clk-based oversampling counter.
- Assembles one 8-bit character, LSB first, and presents it to the CPU with a received flag, framing-error flag and overrun flag.
- Sits directly downstream of the transmitter's `out`. It is intended for loopback test of the lab pair and for CPU-side receive.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit period; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  1  serial line; asynchronous to clk; idles high.
- enable  input  1  receiver enable; low holds the receiver in IDLE.
- read  input  1  CPU acknowledge; a one-cycle pulse clears charReceived and overrun.
- toCPU  output  DATA_BITS  last good character received.
- charReceived  output  1  high from character completion until read or reset.
- frameError  output  1  stop bit sampled low on the most recent frame.
- overrun  output  1  a new character completed while charReceived was already high.

Behaviour:
- Frame format: idle high, 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high).
- Input synchronizer:
  - `in` passes through 2 flops; all decisions use the synchronized value `s`.
  - The synchronizer resets to 1.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Counters and shift register clear to 0.
  - toCPU=0, charReceived=0, frameError=0, overrun=0.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** when enable=1 and s=0, go to START with the counter at 0. Call that cycle T0.
  - **START:** count to CLKS_PER_BIT/2−1, which is the mid-point of the start bit.
    - If s=0 there, go to DATA with the counter and bit index at 0.
    - If s=1 there, it is a false start: go to IDLE and leave all flags unchanged.
  - **DATA:** count CLKS_PER_BIT−1, then sample s into the shift register (shift right, new bit into the MSB) and increment the bit index.
    - After the DATA_BITS-th sample, go to STOP.
    - Bit i (0-based) is sampled at T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - **STOP:** sample at T0 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT.
    - If s=1: on the next edge toCPU ← shift register, charReceived ← 1, frameError ← 0, overrun ← charReceived (the old value). Then go to IDLE.
    - If s=0: frameError ← 1, toCPU and charReceived are unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until s=1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- Completion latency:
  - charReceived rises 1 cycle after the stop sample.
  - With defaults, that is T0+153, which is the raw falling edge +155.
- enable:
  - enable=0 in any state forces IDLE on the next edge and discards partial data.
  - Flags and toCPU hold their values.
  - After enable returns high, a line that is already low is not treated as a start until it has been seen high in IDLE. IDLE requires a 1→0 transition of s.
- read:
  - read=1 clears charReceived and overrun on the next edge. frameError is cleared only by the next good frame or by reset.
  - read on the same cycle as a good completion: the completion wins. charReceived=1, toCPU = new character, overrun=0.
- Back-to-back frames: the receiver returns to IDLE at the stop-bit mid-point, so a start bit that immediately follows the stop bit is caught.
- toCPU changes only on a good completion.

Test Plan:
- Basic receive:
  - Stimulus: reset low then high; enable=1; drive frame 0xA5 at 16 clk/bit.
  - Required: toCPU=0xA5; charReceived rises exactly 155 cycles after the raw start edge; frameError=0; overrun=0.
- Back-to-back without read:
  - Stimulus: frames 0x3C then 0xC3, no read.
  - Required: toCPU=0xC3, charReceived=1, overrun=1.
  - Then pulse read: charReceived=0, overrun=0.
- Framing error:
  - Stimulus: frame 0x55 with stop bit low, line held low for 40 more bit periods, then high, then frame 0x0F.
  - Required: after 0x55, frameError=1 and toCPU is unchanged. No spurious frames while the line is low. After 0x0F, toCPU=0x0F and frameError=0.
- False start:
  - Stimulus: a 4-clk low glitch on an idle line.
  - Required: state returns to IDLE; no flag changes; a following 0x81 frame is received correctly.
- Mid-frame abort:
  - Stimulus: deassert enable during data bit 3 of a frame, or assert reset (low) there.
  - Required with enable: the partial frame is discarded and toCPU and flags keep their prior values.
  - Required with reset: all outputs are 0 immediately, with no clock needed.
- Loopback:
  - Stimulus: connect the lab 4 transmitter's `out` to `in`; send 0x00, 0xFF, 0x6E.
  - Required: each received in order, with frameError=0 throughout.
